// File: rtl/wb_port_arbiter_pkg.sv
// Shared write-back definitions: port widths, requester indices and the
// per-requester result record used on the integer register-file port.
package wb_port_arbiter_pkg;

    localparam int WB_XLEN       = 32;
    localparam int WB_REG_ADDR_W = 5;
    localparam int WB_N_REQ      = 3;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_LSU = 2'd1,
        WB_SRC_MF  = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [WB_REG_ADDR_W-1:0] rd;
        logic [WB_XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant searched upward from a
// pointer that moves just past the last winner. Reusable for other RF ports.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;
    int               cand;

    always_comb begin
        grant = '0;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        cand  = 0;
        // Grant is held off during reset so nothing transfers while state clears.
        if (!rst && !hold) begin
            for (int k = 0; k < N; k++) begin
                cand = (int'(ptr_q) + k) % N;
                idx  = PTR_W'(cand);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        if (found) begin
            grant[win] = 1'b1;
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (win == PTR_W'(N - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Integer register-file write-port arbiter: round-robin grant among result
// producers, payload mux, x0 filter and a registered single write per cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int XLEN       = WB_XLEN,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int N_REQ      = WB_N_REQ
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [N_REQ*XLEN-1:0]       req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        port_hold,
    output logic                        rf_we,
    output logic [REG_ADDR_W-1:0]       rf_rd,
    output logic [XLEN-1:0]             rf_data,
    output logic [N_REQ-1:0]            busy_mask
);

    logic [N_REQ-1:0]      grant;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic                  rf_we_q,   rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q,   rf_rd_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;

    // rstn is an active-high reset despite its name.
    rr_arbiter #(
        .N(N_REQ)
    ) u_rr (
        .clk   (clk),
        .rst   (rstn),
        .req   (req_valid),
        .hold  (port_hold),
        .grant (grant)
    );

    assign req_ready = grant;
    assign busy_mask = req_valid & ~grant;
    assign xfer      = |(req_valid & grant);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
        // A transfer to x0 retires the requester but never reaches the file.
        rf_we_d   = xfer && (sel_rd != '0);
        rf_rd_d   = rf_we_d ? sel_rd   : rf_rd_q;
        rf_data_d = rf_we_d ? sel_data : rf_data_q;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table with hand-derived grants, a write
// scoreboard queue, and a hand sequence for pointer wrap plus async reset.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int XW = WB_XLEN;
    localparam int RW = WB_REG_ADDR_W;
    localparam int NR = WB_N_REQ;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_valid;
    logic [NR*RW-1:0]  req_rd;
    logic [NR*XW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              port_hold;
    logic              rf_we;
    logic [RW-1:0]     rf_rd;
    logic [XW-1:0]     rf_data;
    logic [NR-1:0]     busy_mask;

    wb_port_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .port_hold (port_hold),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [NR-1:0]    valid;
        logic [NR*RW-1:0] rd;
        logic [NR*XW-1:0] data;
        logic             hold;
        logic [NR-1:0]    exp_ready;
        logic [NR-1:0]    exp_busy;
    } vec_t;

    typedef struct {
        logic    we;
        logic    chk_payload;
        wb_req_t w;
    } exp_t;

    vec_t    vecs[$];
    exp_t    sb[$];
    int      total = 0;
    int      bad = 0;
    logic [RW-1:0] last_rd = '0;
    logic [XW-1:0] last_data = '0;

    function automatic vec_t mk(string n, logic [2:0] v,
                                logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2,
                                logic h, logic [2:0] rdy, logic [2:0] bsy);
        vec_t t;
        t.name = n; t.valid = v; t.rd = {r2, r1, r0}; t.data = {d2, d1, d0};
        t.hold = h; t.exp_ready = rdy; t.exp_busy = bsy;
        return t;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic push_expected(vec_t t);
        exp_t e;
        int   g;
        g = -1;
        for (int i = 0; i < NR; i++) if (t.exp_ready[i]) g = i;
        e.we = 1'b0;
        e.chk_payload = 1'b1;
        e.w.rd = last_rd;
        e.w.data = last_data;
        if (g >= 0) begin
            if (t.rd[g*RW +: RW] != '0) begin
                e.we = 1'b1;
                e.w.rd = t.rd[g*RW +: RW];
                e.w.data = t.data[g*XW +: XW];
                last_rd = e.w.rd;
                last_data = e.w.data;
            end else begin
                e.chk_payload = 1'b0;
            end
        end
        sb.push_back(e);
    endtask

    task automatic pop_check(string n);
        exp_t e;
        if (sb.size() == 0) begin
            chk({n, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({n, "_we"}, 32'(rf_we), 32'(e.we));
        if (e.chk_payload) begin
            chk({n, "_rd"}, 32'(rf_rd), 32'(e.w.rd));
            chk({n, "_data"}, rf_data, e.w.data);
        end
    endtask

    initial begin
        rstn = 1'b1;
        req_valid = '1;
        req_rd = '0;
        req_data = '0;
        port_hold = 1'b0;

        vecs.push_back(mk("rr0", 3'b111, 1, 2, 3, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 0, 3'b001, 3'b110));
        vecs.push_back(mk("rr1", 3'b111, 1, 2, 3, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 0, 3'b010, 3'b101));
        vecs.push_back(mk("rr2", 3'b111, 1, 2, 3, 32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 0, 3'b100, 3'b011));
        vecs.push_back(mk("rr3", 3'b111, 4, 4, 4, 32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 0, 3'b001, 3'b110));
        vecs.push_back(mk("rr4", 3'b111, 4, 4, 4, 32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 0, 3'b010, 3'b101));
        vecs.push_back(mk("rr5", 3'b111, 4, 4, 4, 32'h1111_0001, 32'h2222_0001, 32'h3333_0001, 0, 3'b100, 3'b011));
        vecs.push_back(mk("alu", 3'b001, 5, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 3'b001, 3'b000));
        vecs.push_back(mk("x0", 3'b010, 0, 0, 0, 0, 32'h0000_0055, 0, 0, 3'b010, 3'b000));
        vecs.push_back(mk("lsu3", 3'b010, 0, 3, 0, 0, 32'h0000_0033, 0, 0, 3'b010, 3'b000));
        vecs.push_back(mk("hold0", 3'b001, 7, 0, 0, 32'h0000_0077, 0, 0, 1, 3'b000, 3'b001));
        vecs.push_back(mk("hold1", 3'b001, 7, 0, 0, 32'h0000_0077, 0, 0, 1, 3'b000, 3'b001));
        vecs.push_back(mk("hold2", 3'b001, 7, 0, 0, 32'h0000_0077, 0, 0, 1, 3'b000, 3'b001));
        vecs.push_back(mk("release", 3'b001, 7, 0, 0, 32'h0000_0077, 0, 0, 0, 3'b001, 3'b000));
        vecs.push_back(mk("mf", 3'b100, 0, 0, 9, 0, 0, 32'h0000_0099, 0, 3'b100, 3'b000));
        vecs.push_back(mk("wrap", 3'b011, 10, 11, 0, 32'h0000_00AA, 32'h0000_00BB, 0, 0, 3'b001, 3'b010));
        vecs.push_back(mk("idle", 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000));

        // Reset with every requester asking.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy_mask), 32'h7);
        chk("rst_we", 32'(rf_we), 32'h0);
        chk("rst_rd", 32'(rf_rd), 32'h0);
        chk("rst_data", rf_data, 32'h0);
        @(negedge clk);
        rstn = 1'b0;

        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            req_rd = vecs[i].rd;
            req_data = vecs[i].data;
            port_hold = vecs[i].hold;
            #1;
            chk({vecs[i].name, "_ready"}, 32'(req_ready), 32'(vecs[i].exp_ready));
            chk({vecs[i].name, "_busy"}, 32'(busy_mask), 32'(vecs[i].exp_busy));
            push_expected(vecs[i]);
            @(posedge clk);
            #1;
            pop_check(vecs[i].name);
            @(negedge clk);
        end

        // Pointer now 1: LSU wins, then reset lands while its write is registered.
        req_valid = 3'b011;
        req_rd = {5'd0, 5'd13, 5'd12};
        req_data = {32'h0, 32'h0000_0D0D, 32'h0000_0C0C};
        #1;
        chk("pre_rst_ready", 32'(req_ready), 32'h2);
        @(posedge clk);
        #1;
        chk("pre_rst_we", 32'(rf_we), 32'h1);
        chk("pre_rst_rd", 32'(rf_rd), 32'd13);
        #2;
        rstn = 1'b1;
        #1;
        chk("async_we", 32'(rf_we), 32'h0);
        chk("async_rd", 32'(rf_rd), 32'h0);
        chk("async_data", rf_data, 32'h0);
        chk("async_ready", 32'(req_ready), 32'h0);
        sb.delete();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        chk("post_rst_busy", 32'(busy_mask), 32'h2);
        @(posedge clk);
        #1;
        chk("post_rst_we", 32'(rf_we), 32'h1);
        chk("post_rst_rd", 32'(rf_rd), 32'd12);
        chk("post_rst_data", rf_data, 32'h0000_0C0C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between the result producers of the RV32I-MAF core: ALU, load unit, and multi-cycle M/F units.
- Sits between the execute/memory stages and the register file, replacing the direct write-back path.
- Arbitrates round-robin with a valid/ready handshake per requester.
- Registers the granted write so the register file sees one clean write per cycle.

Parameters:
- XLEN, 32, data width of results and of the write port.
- REG_ADDR_W, 5, register index width.
- N_REQ, 3, number of requesters; index 0 = ALU, 1 = load unit, 2 = M/F unit.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous, active-high reset (asserted = 1, despite the port name).
- req_valid  in  N_REQ  requester i holds a result.
- req_rd  in  N_REQ*REG_ADDR_W  destination register per requester; slice i = bits [i*REG_ADDR_W +: REG_ADDR_W].
- req_data  in  N_REQ*XLEN  result per requester; slice i = bits [i*XLEN +: XLEN].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- port_hold  in  1  register-file port reserved externally (e.g. debug write); no grants while high.
- rf_we  out  1  register-file write enable.
- rf_rd  out  REG_ADDR_W  register-file write index.
- rf_data  out  XLEN  register-file write data.
- busy_mask  out  N_REQ  requesters with valid high but not granted this cycle (stall visibility for the hazard unit).

Behaviour:
- Reset: rf_we=0, rf_rd=0, rf_data=0, round-robin pointer=0. req_ready is combinational and is 0 while rstn is asserted.
- Grant (combinational, same cycle):
  - If port_hold=1, req_ready=0.
  - Otherwise req_ready is one-hot on the first valid requester found searching from the pointer upward, modulo N_REQ.
  - No valid requester gives req_ready=0.
  - req_ready never depends on the requester's own ready state; no combinational loop.
- Pointer: after a transfer from requester g, pointer = (g+1) mod N_REQ. It wraps from N_REQ-1 to 0. With no transfer it holds.
- Write register: on transfer, the cycle after is rf_we=1, rf_rd=req_rd[g], rf_data=req_data[g]. Latency is exactly 1 cycle, and one write per cycle is sustained.
- No transfer: the next cycle has rf_we=0; rf_rd and rf_data hold their last values.
- x0: a transfer with rd=0 completes the handshake, but the following cycle has rf_we=0. x0 is never written.
- Requester obligation: req_valid, req_rd and req_data stay stable until the transfer.
  - The arbiter tolerates a requester dropping valid before its grant; nothing is latched.
- Same rd from two requesters in one cycle: the winner writes first, the other writes in a later cycle. Write order = grant order. The issue logic is responsible for correct program order.
- busy_mask = req_valid & ~req_ready, every cycle, including under port_hold.
- port_hold asserted mid-stream: a write already registered still appears on the next cycle, and no new grant is issued.
- Reset mid-operation: all state clears immediately and asynchronously, and an in-flight registered write is dropped (rf_we=0).

Decomposition:
- The shared package (alongside the instruction package) holds:
  - XLEN and the register-index width constant.
  - The requester index enum: WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MF=2.
  - A wb_req_t struct {rd, data}.
- One natural sub-module: rr_arbiter, a generic N-way round-robin grant with pointer state, req/hold inputs and one-hot grant output. It is reusable for the later FP register-file port.
- The top level adds the data mux, the x0 filter and the output register.

Test Plan:
- Reset: assert rstn with all req_valid=1 -> req_ready=000, rf_we=0, rf_rd=0, rf_data=0.
- Single requester: ALU valid, rd=5, data=0xDEADBEEF, pointer 0 -> req_ready=001 same cycle; next cycle rf_we=1, rf_rd=5, rf_data=0xDEADBEEF.
- Round-robin fairness:
  - Setup: all three valid and held for 6 cycles.
  - Required: grants 0,1,2,0,1,2.
  - Required: rf_data sequence follows the grants.
  - Required: busy_mask shows the two losers each cycle.
- x0 filter: LSU valid with rd=0 -> handshake completes, next cycle rf_we=0; then rd=3 -> rf_we=1, rf_rd=3.
- port_hold: hold=1 for 3 cycles with ALU valid -> req_ready=000, busy_mask=001, rf_we=0; on release, grant next cycle and write one cycle later.
- Pointer wrap plus async reset: after a grant to requester 2, only ALU is valid -> grant 0. Assert rstn mid-transfer -> rf_we drops immediately and the pointer returns to 0.
